// File: rtl/branch_predictor_if.sv
// Fetch-lookup, execute-resolution and performance-counter signals exchanged
// between the pipeline (master) and the branch predictor (slave).
interface branch_predictor_if #(
  parameter int XLEN = 32
);
  // ex_valid_i qualifies every ex_* field for exactly one cycle. The predictor
  // has no ready signal and accepts each valid resolution in the cycle it is
  // presented. mispredict_o and redirect_pc_o are valid in that same cycle.
  logic [XLEN-1:0] if_pc_i;
  logic            pred_taken_o;
  logic [XLEN-1:0] pred_target_o;
  logic            ex_valid_i;
  logic [XLEN-1:0] ex_pc_i;
  logic            ex_is_branch_i;
  logic            ex_is_jump_i;
  logic            ex_taken_i;
  logic [XLEN-1:0] ex_target_i;
  logic            ex_pred_taken_i;
  logic [XLEN-1:0] ex_pred_target_i;
  logic            mispredict_o;
  logic [XLEN-1:0] redirect_pc_o;
  logic            clear_cnt_i;
  logic [31:0]     branch_cnt_o;
  logic [31:0]     mispred_cnt_o;

  modport master (
    output if_pc_i, ex_valid_i, ex_pc_i, ex_is_branch_i, ex_is_jump_i,
           ex_taken_i, ex_target_i, ex_pred_taken_i, ex_pred_target_i,
           clear_cnt_i,
    input  pred_taken_o, pred_target_o, mispredict_o, redirect_pc_o,
           branch_cnt_o, mispred_cnt_o
  );

  modport slave (
    input  if_pc_i, ex_valid_i, ex_pc_i, ex_is_branch_i, ex_is_jump_i,
           ex_taken_i, ex_target_i, ex_pred_taken_i, ex_pred_target_i,
           clear_cnt_i,
    output pred_taken_o, pred_target_o, mispredict_o, redirect_pc_o,
           branch_cnt_o, mispred_cnt_o
  );
endinterface

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with per-entry saturating counters and jump flags.
// Zero-latency prediction at fetch; training and mispredict detection at execute.
module branch_predictor #(
  parameter int XLEN    = 32,
  parameter int ENTRIES = 16,
  parameter int CNT_W   = 2
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  branch_predictor_if.slave bp
);
  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = XLEN - IDX_W - 2;

  localparam logic [CNT_W-1:0] CNT_WEAK_TAKEN = {1'b1, {(CNT_W-1){1'b0}}};
  localparam logic [CNT_W-1:0] CNT_MAX        = '1;
  localparam logic [CNT_W-1:0] CNT_MIN        = '0;

  logic [ENTRIES-1:0] valid_q;
  logic [ENTRIES-1:0] jump_q;
  logic [TAG_W-1:0]   tag_q    [ENTRIES];
  logic [XLEN-1:0]    target_q [ENTRIES];
  logic [CNT_W-1:0]   cnt_q    [ENTRIES];
  logic [31:0]        branch_cnt_q;
  logic [31:0]        mispred_cnt_q;

  logic [IDX_W-1:0] if_idx;
  logic [TAG_W-1:0] if_tag;
  logic             if_hit;
  logic             pred_taken;

  logic [IDX_W-1:0] ex_idx;
  logic [TAG_W-1:0] ex_tag;
  logic             ex_hit;
  logic             ex_is_cf;
  logic             actual_taken;
  logic             mispredict;
  logic [CNT_W-1:0] upd_cnt;

  // Fetch-side lookup reads the registered table, so a same-cycle write is not visible.
  always_comb begin
    if_idx     = bp.if_pc_i[IDX_W+1:2];
    if_tag     = bp.if_pc_i[XLEN-1:IDX_W+2];
    if_hit     = valid_q[if_idx] && (tag_q[if_idx] == if_tag);
    pred_taken = if_hit && (jump_q[if_idx] || cnt_q[if_idx][CNT_W-1]);
  end

  assign bp.pred_taken_o  = pred_taken;
  assign bp.pred_target_o = pred_taken ? target_q[if_idx] : bp.if_pc_i + XLEN'(4);

  always_comb begin
    ex_idx       = bp.ex_pc_i[IDX_W+1:2];
    ex_tag       = bp.ex_pc_i[XLEN-1:IDX_W+2];
    ex_hit       = valid_q[ex_idx] && (tag_q[ex_idx] == ex_tag);
    ex_is_cf     = bp.ex_is_branch_i || bp.ex_is_jump_i;
    actual_taken = bp.ex_taken_i && ex_is_cf;
    mispredict   = bp.ex_valid_i &&
                   ((bp.ex_pred_taken_i != actual_taken) ||
                    (bp.ex_pred_taken_i && actual_taken &&
                     (bp.ex_pred_target_i != bp.ex_target_i)));
  end

  assign bp.mispredict_o  = mispredict;
  assign bp.redirect_pc_o = actual_taken ? bp.ex_target_i : bp.ex_pc_i + XLEN'(4);

  always_comb begin
    upd_cnt = cnt_q[ex_idx];
    if (actual_taken) begin
      if (upd_cnt != CNT_MAX) upd_cnt = upd_cnt + CNT_W'(1);
    end else begin
      if (upd_cnt != CNT_MIN) upd_cnt = upd_cnt - CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= '0;
      jump_q  <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        cnt_q[i]    <= '0;
      end
    end else if (bp.ex_valid_i) begin
      if (ex_is_cf) begin
        if (ex_hit) begin
          cnt_q[ex_idx]  <= upd_cnt;
          jump_q[ex_idx] <= bp.ex_is_jump_i;
          if (actual_taken) target_q[ex_idx] <= bp.ex_target_i;
        end else if (actual_taken) begin
          valid_q[ex_idx]  <= 1'b1;
          tag_q[ex_idx]    <= ex_tag;
          target_q[ex_idx] <= bp.ex_target_i;
          cnt_q[ex_idx]    <= CNT_WEAK_TAKEN;
          jump_q[ex_idx]   <= bp.ex_is_jump_i;
        end
      end else if (ex_hit) begin
        // A non-control-flow instruction at this PC means the entry is stale.
        valid_q[ex_idx] <= 1'b0;
      end
    end
  end

  // Clear wins over any increment in the same cycle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      branch_cnt_q  <= '0;
      mispred_cnt_q <= '0;
    end else if (bp.clear_cnt_i) begin
      branch_cnt_q  <= '0;
      mispred_cnt_q <= '0;
    end else begin
      if (bp.ex_valid_i && ex_is_cf) branch_cnt_q  <= branch_cnt_q + 32'd1;
      if (mispredict)                mispred_cnt_q <= mispred_cnt_q + 32'd1;
    end
  end

  assign bp.branch_cnt_o  = branch_cnt_q;
  assign bp.mispred_cnt_o = mispred_cnt_q;
endmodule

// File: doc/branch_predictor.md
BRANCH_PREDICTOR -- requirements
Module: branch_predictor

Interface
REQ-001 SHALL have parameter XLEN, 32, datapath/PC width.
REQ-002 SHALL have parameter ENTRIES, 16, table depth; power of two, at least 2; IDX_W = log2(ENTRIES).
REQ-003 SHALL have parameter CNT_W, 2, saturating-counter width; at least 2.
REQ-004 SHALL have port clk_i  input  1  sole clock, rising edge.
REQ-005 SHALL have port rst_ni  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port if_pc_i  input  XLEN  fetch PC to predict.
REQ-007 SHALL have port pred_taken_o  output  1  predicted taken for if_pc_i.
REQ-008 SHALL have port pred_target_o  output  XLEN  predicted next PC for if_pc_i.
REQ-009 SHALL have port ex_valid_i  input  1  resolution information valid this cycle.
REQ-010 SHALL have port ex_pc_i  input  XLEN  PC of the resolving instruction.
REQ-011 SHALL have port ex_is_branch_i  input  1  conditional branch (BEQ/BNE/BLT/BGE/BLTU/BGEU).
REQ-012 SHALL have port ex_is_jump_i  input  1  JAL or valid JALR.
REQ-013 SHALL have port ex_taken_i  input  1  actual outcome.
REQ-014 SHALL have port ex_target_i  input  XLEN  actual target when taken.
REQ-015 SHALL have port ex_pred_taken_i  input  1  prediction carried down the pipe with this instruction.
REQ-016 SHALL have port ex_pred_target_i  input  XLEN  predicted target carried down the pipe.
REQ-017 SHALL have port mispredict_o  output  1  redirect request.
REQ-018 SHALL have port redirect_pc_o  output  XLEN  correct next PC.
REQ-019 SHALL have port clear_cnt_i  input  1  synchronous clear of the performance counters.
REQ-020 SHALL have port branch_cnt_o  output  32  resolved branch/jump count.
REQ-021 SHALL have port mispred_cnt_o  output  32  mispredict count.

Function
REQ-022 SHALL hold ENTRIES entries, each with: valid, tag (PC[XLEN-1:IDX_W+2]), target (XLEN), counter (CNT_W), jump flag.
REQ-023 SHALL index the table with PC[IDX_W+1:2]; hit = valid and stored tag equals PC tag.
REQ-024 SHALL predict combinationally in the same cycle (zero latency): pred_taken_o = hit and (jump flag or counter MSB).
REQ-025 SHALL drive pred_target_o = stored target when pred_taken_o, else if_pc_i + 4 (modulo 2^XLEN).
REQ-026 SHALL assert mispredict_o combinationally when ex_valid_i and either (a) ex_pred_taken_i differs from the actual outcome or (b) both are taken and ex_pred_target_i differs from ex_target_i; the actual outcome is ex_taken_i, forced to 0 when neither ex_is_branch_i nor ex_is_jump_i.
REQ-027 SHALL drive redirect_pc_o = ex_target_i when the actual outcome is taken, else ex_pc_i + 4; mispredict_o = 0 whenever ex_valid_i = 0.
REQ-028 SHALL, on ex_valid_i with a hit at ex_pc_i and (branch or jump): increment the counter when taken and decrement it when not taken, saturating at all-ones and zero; write the target when taken; set the jump flag to ex_is_jump_i.
REQ-029 SHALL, on ex_valid_i with a miss and taken (branch or jump): allocate/overwrite the indexed entry with valid=1, new tag, target, counter = 2^(CNT_W-1) (weakly taken), jump flag.
REQ-030 SHALL NOT allocate on a not-taken miss.
REQ-031 SHALL, on ex_valid_i for a non-branch/non-jump that hits, clear that entry's valid bit.
REQ-032 SHALL commit table writes at the rising edge; a same-cycle lookup at the index being written returns the pre-write contents.
REQ-033 SHALL increment branch_cnt_o once per ex_valid_i cycle with branch or jump, and mispred_cnt_o once per mispredict_o cycle; both wrap from 0xFFFFFFFF to 0.
REQ-034 SHALL let clear_cnt_i zero both counters at the next edge, taking priority over a simultaneous increment.

Reset
REQ-035 SHALL, while rst_ni = 0 (asynchronous), clear every valid bit, every counter, jump flags, branch_cnt_o and mispred_cnt_o; tags and targets are also cleared to 0.
REQ-036 SHALL, after reset, give pred_taken_o = 0 and pred_target_o = if_pc_i + 4 for every PC; reset asserted mid-update discards that update.

Verification
REQ-037 SHALL cover: after reset, if_pc_i = 0x100 -> pred_taken_o = 0, pred_target_o = 0x104, both counters 0.
REQ-038 SHALL cover: resolve a taken branch at PC 0x100 to 0x80 (pred not-taken) -> mispredict_o = 1, redirect_pc_o = 0x80; next cycle if_pc_i = 0x100 -> taken, 0x80 (counter 2).
REQ-039 SHALL cover: with CNT_W = 2, three further taken resolutions then three not-taken resolutions at 0x100 -> counter saturates at 3, then reaches 0, and prediction becomes not-taken after the second not-taken.
REQ-040 SHALL cover: an alias PC (same index, different tag, e.g. 0x100 + 4*ENTRIES) taken -> it replaces the entry, and 0x100 then misses.
REQ-041 SHALL cover: a JAL at 0x200 -> 0x300, then the entry's counter is decremented to 0 -> still predicted taken (jump flag set).
REQ-042 SHALL cover: clear_cnt_i together with a mispredicting resolution -> both counters read 0 next cycle; mispred_cnt_o forced to 0xFFFFFFFF, then one mispredict -> 0.
